// File: rtl/uart_sched_pkg.sv
// Shared types and frame-timing helpers for the UART link scheduler.
// Default timing constants match a 868-clock bit period with 11-bit frames.
package uart_sched_pkg;

    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_FRAME_BITS   = 11;
    localparam int DEF_GAP_BITS     = 1;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_WAIT = 1'b1
    } tx_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

    // Clocks from one Transmit strobe until the next frame may start, gap included.
    function automatic int calcFrameCycles(input int clksPerBit, input int frameBits,
                                           input int gapBits);
        return (frameBits + gapBits) * clksPerBit;
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin winner search over NUM_REQ requesters.
// The pointer remembers the last winner and only moves when a grant is loaded.
module uart_rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               load,
    output logic               anyReq,
    output logic [IDX_W-1:0]   winner,
    output logic [NUM_REQ-1:0] grantOneHot
);

    logic [IDX_W-1:0] pointer;

    // Scan offsets from farthest to nearest so the nearest set bit after the pointer wins.
    always_comb begin
        int idx;
        anyReq = |req;
        winner = pointer;
        idx    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(pointer) + i) % NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        grantOneHot         = '0;
        grantOneHot[winner] = anyReq;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pointer <= IDX_W'(NUM_REQ - 1);
        end else if (load) begin
            pointer <= winner;
        end
    end

endmodule

// File: rtl/uart_link_scheduler.sv
// Shares one UART transmitter among NUM_REQ requesters with frame pacing, and
// services the UART receive interrupt onto a valid/ready consumer port.
module uart_link_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FRAME_BITS   = DEF_FRAME_BITS,
    parameter int GAP_BITS     = DEF_GAP_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   ReqValid,
    input  logic [8*NUM_REQ-1:0] ReqData,
    output logic [NUM_REQ-1:0]   ReqGrant,
    output logic                 TxBusy,
    output logic [7:0]           DataToTransmit,
    output logic                 Transmit,
    input  logic                 RxInterrupt,
    input  logic [7:0]           ReceivedData,
    input  logic                 ParityError,
    output logic                 ClearInterrupt,
    output logic                 RxValid,
    output logic [7:0]           RxData,
    output logic                 RxParityErr,
    output logic                 RxOverrun,
    input  logic                 RxReady,
    output tx_state_t            TxState,
    output rx_state_t            RxState
);

    localparam int FRAME_CYCLES = calcFrameCycles(CLKS_PER_BIT, FRAME_BITS, GAP_BITS);
    localparam int CNT_W        = $clog2(FRAME_CYCLES);
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                 anyReq;
    logic [IDX_W-1:0]     winner;
    logic [NUM_REQ-1:0]   winnerOneHot;
    logic                 txLoad;
    logic [CNT_W-1:0]     frameCnt;

    assign txLoad = (TxState == T_IDLE) && anyReq;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .req         (ReqValid),
        .load        (txLoad),
        .anyReq      (anyReq),
        .winner      (winner),
        .grantOneHot (winnerOneHot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TxState        <= T_IDLE;
            frameCnt       <= '0;
            ReqGrant       <= '0;
            TxBusy         <= 1'b0;
            DataToTransmit <= 8'h00;
            Transmit       <= 1'b0;
        end else begin
            Transmit <= 1'b0;
            ReqGrant <= '0;
            case (TxState)
                T_IDLE: begin
                    if (anyReq) begin
                        DataToTransmit <= ReqData[{winner, 3'b000} +: 8];
                        Transmit       <= 1'b1;
                        ReqGrant       <= winnerOneHot;
                        TxBusy         <= 1'b1;
                        frameCnt       <= '0;
                        TxState        <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    // Requests are not resampled here; the frame runs to its full length.
                    frameCnt <= frameCnt + 1'b1;
                    if (frameCnt == CNT_W'(FRAME_CYCLES - 1)) begin
                        TxBusy  <= 1'b0;
                        TxState <= T_IDLE;
                    end
                end
                default: TxState <= T_IDLE;
            endcase
        end
    end

    // Consumer port: a byte moves when RxValid and RxReady are both high at a
    // rising edge; RxData/RxParityErr stay stable while RxValid waits for RxReady.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RxState        <= R_IDLE;
            ClearInterrupt <= 1'b0;
            RxValid        <= 1'b0;
            RxData         <= 8'h00;
            RxParityErr    <= 1'b0;
            RxOverrun      <= 1'b0;
        end else begin
            if (RxValid && RxReady) begin
                RxValid   <= 1'b0;
                RxOverrun <= 1'b0;
            end
            case (RxState)
                R_IDLE: begin
                    if (RxInterrupt) begin
                        ClearInterrupt <= 1'b1;
                        RxState        <= R_ACK;
                        if (!RxValid || RxReady) begin
                            RxData      <= ReceivedData;
                            RxParityErr <= ParityError;
                            RxValid     <= 1'b1;
                        end else begin
                            RxOverrun <= 1'b1;
                        end
                    end
                end
                R_ACK: begin
                    if (!RxInterrupt) begin
                        ClearInterrupt <= 1'b0;
                        RxState        <= R_IDLE;
                    end
                end
                default: RxState <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_link_scheduler.sv
// Bench for uart_link_scheduler: table-driven arbitration vectors, scoreboarded
// TX/RX results, and hand sequences for pacing, overrun, reset and default timing.
module tb_uart_link_scheduler;
    import uart_sched_pkg::*;

    localparam int NR  = 4;
    localparam int CPB = 4;
    localparam int FC  = 48;

    logic        clk;
    logic        reset;
    logic [3:0]  ReqValid;
    logic [31:0] ReqData;
    logic [3:0]  ReqGrant;
    logic        TxBusy;
    logic [7:0]  DataToTransmit;
    logic        Transmit;
    logic        RxInterrupt;
    logic [7:0]  ReceivedData;
    logic        ParityError;
    logic        ClearInterrupt;
    logic        RxValid;
    logic [7:0]  RxData;
    logic        RxParityErr;
    logic        RxOverrun;
    logic        RxReady;
    tx_state_t   TxState;
    rx_state_t   RxState;

    logic [3:0]  d2ReqValid;
    logic [31:0] d2ReqData;
    logic [3:0]  d2ReqGrant;
    logic        d2TxBusy;
    logic [7:0]  d2Data;
    logic        d2Transmit;
    logic        d2ClearInterrupt;
    logic        d2RxValid;
    logic [7:0]  d2RxData;
    logic        d2RxParityErr;
    logic        d2RxOverrun;
    tx_state_t   d2TxState;
    rx_state_t   d2RxState;

    uart_link_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqGrant(ReqGrant), .TxBusy(TxBusy), .DataToTransmit(DataToTransmit),
        .Transmit(Transmit), .RxInterrupt(RxInterrupt), .ReceivedData(ReceivedData),
        .ParityError(ParityError), .ClearInterrupt(ClearInterrupt), .RxValid(RxValid),
        .RxData(RxData), .RxParityErr(RxParityErr), .RxOverrun(RxOverrun),
        .RxReady(RxReady), .TxState(TxState), .RxState(RxState)
    );

    uart_link_scheduler dut2 (
        .clk(clk), .reset(reset), .ReqValid(d2ReqValid), .ReqData(d2ReqData),
        .ReqGrant(d2ReqGrant), .TxBusy(d2TxBusy), .DataToTransmit(d2Data),
        .Transmit(d2Transmit), .RxInterrupt(1'b0), .ReceivedData(8'h00),
        .ParityError(1'b0), .ClearInterrupt(d2ClearInterrupt), .RxValid(d2RxValid),
        .RxData(d2RxData), .RxParityErr(d2RxParityErr), .RxOverrun(d2RxOverrun),
        .RxReady(1'b0), .TxState(d2TxState), .RxState(d2RxState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [11:0] txExpQ[$];
    logic [8:0]  expQ[$];

    bit prevTx;
    bit spacingCheck;
    bit lastTxSeen;
    int lastTx;
    int busyCnt;

    typedef struct {
        logic [3:0] reqValid;
        logic [3:0] expGrant;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [31:0] d, input logic [3:0] g);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < NR; i++) if (g[i]) b = d[8*i +: 8];
        return b;
    endfunction

    // scoreboard: observe the DUT at the falling edge, with inputs for the next edge applied
    task automatic monitorStep();
        logic [11:0] txExp;
        logic [8:0]  rxExp;
        if (!reset) begin
            prevTx     = 1'b0;
            busyCnt    = 0;
            lastTxSeen = 1'b0;
        end else begin
            if (prevTx) check("tx_pulse_width", 32'({Transmit, ReqGrant}), 32'h0);
            if (Transmit) begin
                if (txExpQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=0x%0h required=none", {ReqGrant, DataToTransmit});
                end else begin
                    txExp = txExpQ.pop_front();
                    check("tx_grant_data", 32'({ReqGrant, DataToTransmit}), 32'(txExp));
                end
                if (spacingCheck && lastTxSeen) check("tx_spacing", 32'(cycle - lastTx), 32'(FC + 1));
                lastTx     = cycle;
                lastTxSeen = spacingCheck;
            end
            prevTx = Transmit;
            if (TxBusy) begin
                busyCnt++;
            end else if (busyCnt > 0) begin
                check("tx_busy_len", 32'(busyCnt), 32'(FC));
                busyCnt = 0;
            end
            if (RxValid && RxReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected actual=0x%0h required=none", {RxParityErr, RxData});
                end else begin
                    rxExp = expQ.pop_front();
                    check("rx_byte", 32'({RxParityErr, RxData}), 32'(rxExp));
                end
            end
        end
    endtask

    task automatic tick();
        monitorStep();
        @(negedge clk);
        cycle++;
    endtask

    // driver tasks
    task automatic waitGrant(input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (ReqGrant != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("tx_grant_seen", 32'(ok), 32'h1);
    endtask

    task automatic waitIdle(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (!TxBusy) break;
            tick();
        end
        check("tx_idle_seen", 32'(TxBusy), 32'h0);
    endtask

    task automatic rxByte(input logic [7:0] d, input logic pe);
        ReceivedData = d;
        ParityError  = pe;
        RxInterrupt  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ClearInterrupt) break;
        end
        check("rx_clr_set", 32'(ClearInterrupt), 32'h1);
        RxInterrupt = 1'b0;
        tick();
        check("rx_clr_fall", 32'(ClearInterrupt), 32'h0);
    endtask

    initial begin
        logic [31:0] data;
        int grants;
        int t0;

        vecs[0]  = '{4'b0001, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0010};
        vecs[2]  = '{4'b1111, 4'b0100};
        vecs[3]  = '{4'b1111, 4'b1000};
        vecs[4]  = '{4'b1111, 4'b0001};
        vecs[5]  = '{4'b1010, 4'b0010};
        vecs[6]  = '{4'b1010, 4'b1000};
        vecs[7]  = '{4'b0011, 4'b0001};
        vecs[8]  = '{4'b0100, 4'b0100};
        vecs[9]  = '{4'b1001, 4'b1000};
        vecs[10] = '{4'b1001, 4'b0001};
        vecs[11] = '{4'b0110, 4'b0010};

        reset = 1'b0; ReqValid = '0; ReqData = '0; RxInterrupt = 1'b0;
        ReceivedData = '0; ParityError = 1'b0; RxReady = 1'b0;
        d2ReqValid = '0; d2ReqData = '0;
        spacingCheck = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({ReqGrant, TxBusy, DataToTransmit, Transmit, ClearInterrupt,
              RxValid, RxData, RxParityErr, RxOverrun, TxState, RxState}), 32'h0);
        reset = 1'b1;
        tick();
        check("post_reset_idle", 32'({TxBusy, Transmit, RxValid, ClearInterrupt}), 32'h0);

        // table-driven arbitration and pacing
        for (int i = 0; i < 12; i++) begin
            data = (i == 0) ? 32'h0000_00A5 : $urandom();
            ReqData  = data;
            ReqValid = vecs[i].reqValid;
            txExpQ.push_back({vecs[i].expGrant, pick(data, vecs[i].expGrant)});
            waitGrant(5);
            if (i == 0) check("first_data_a5", 32'({TxBusy, DataToTransmit}), 32'h1A5);
            ReqValid = '0;
            ReqData  = $urandom();
            repeat ($urandom_range(0, 3)) tick();
            waitIdle(FC + 5);
            if (i == 0) check("data_hold", 32'(DataToTransmit), 32'hA5);
        end

        // back-to-back with all requesters active; pointer currently at 1
        ReqData  = 32'h4332_2110;
        ReqValid = 4'b1111;
        txExpQ.push_back({4'b0100, 8'h32});
        txExpQ.push_back({4'b1000, 8'h43});
        txExpQ.push_back({4'b0001, 8'h10});
        txExpQ.push_back({4'b0010, 8'h21});
        txExpQ.push_back({4'b0100, 8'h32});
        spacingCheck = 1'b1;
        grants = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (ReqGrant != 4'b0) grants++;
            if (grants == 5) break;
        end
        ReqValid = '0;
        check("b2b_grants", 32'(grants), 32'h5);
        tick();
        waitIdle(FC + 5);
        spacingCheck = 1'b0;

        // RX capture with parity error, then consume
        RxReady = 1'b0;
        expQ.push_back({1'b1, 8'h5A});
        rxByte(8'h5A, 1'b1);
        check("rx_capture", 32'({RxValid, RxParityErr, RxData}), 32'h35A);
        RxReady = 1'b1;
        tick();
        RxReady = 1'b0;
        check("rx_consumed", 32'(RxValid), 32'h0);

        // overrun: second byte dropped while first is held
        expQ.push_back({1'b0, 8'h11});
        rxByte(8'h11, 1'b0);
        rxByte(8'h22, 1'b1);
        check("rx_overrun_hold", 32'({RxOverrun, RxValid, RxParityErr, RxData}), 32'h611);
        RxReady = 1'b1;
        tick();
        RxReady = 1'b0;
        check("rx_overrun_clear", 32'({RxOverrun, RxValid}), 32'h0);

        // capture and consume on the same edge: no overrun
        expQ.push_back({1'b0, 8'h33});
        rxByte(8'h33, 1'b0);
        RxReady = 1'b1;
        expQ.push_back({1'b1, 8'h44});
        rxByte(8'h44, 1'b1);
        check("rx_same_edge", 32'({RxOverrun, RxValid}), 32'h0);
        RxReady = 1'b0;

        // simultaneous TX request and RX interrupt
        data = $urandom();
        ReqData = data;
        ReqValid = 4'b1000;
        txExpQ.push_back({4'b1000, data[31:24]});
        expQ.push_back({1'b0, 8'h9C});
        rxByte(8'h9C, 1'b0);
        ReqValid = '0;
        check("sim_tx_rx", 32'({TxBusy, RxValid, RxData}), 32'h39C);
        RxReady = 1'b1;
        tick();
        RxReady = 1'b0;
        waitIdle(FC + 5);

        // reset in the middle of a frame and of an RX handshake
        ReqData  = $urandom();
        ReqValid = 4'b0001;
        txExpQ.push_back({4'b0001, ReqData[7:0]});
        waitGrant(5);
        ReqValid = '0;
        ReceivedData = 8'h77;
        RxInterrupt  = 1'b1;
        repeat (20) tick();
        reset = 1'b0;
        #1;
        check("async_reset_outputs", 32'({ReqGrant, TxBusy, DataToTransmit, Transmit, ClearInterrupt,
              RxValid, RxData, RxParityErr, RxOverrun, TxState, RxState}), 32'h0);
        RxInterrupt = 1'b0;
        @(negedge clk);
        cycle++;
        tick();
        data = $urandom();
        ReqData  = data;
        ReqValid = 4'b0100;
        reset    = 1'b1;
        txExpQ.push_back({4'b0100, data[23:16]});
        waitGrant(5);
        ReqValid = '0;
        tick();
        waitIdle(FC + 5);
        tick();

        // default timing: 868 clocks per bit, 12 bit-times per frame slot
        d2ReqData  = 32'h0000_0055;
        d2ReqValid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (d2Transmit) break;
        end
        check("d2_first_tx", 32'({d2Transmit, d2Data}), 32'h155);
        t0 = cycle;
        tick();
        for (int k = 0; k < 11000; k++) begin
            if (d2Transmit) break;
            tick();
        end
        d2ReqValid = '0;
        check("d2_spacing", 32'(cycle - t0), 32'd10417);

        check("tx_queue_empty", 32'(txExpQ.size()), 32'h0);
        check("rx_queue_empty", 32'(expQ.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_link_scheduler.md
Name: uart_link_scheduler

Overview:
- Shares the single UART transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Paces each `Transmit` strobe to the frame timing: start bit, 8 data bits, parity, stop, plus an inter-frame gap.
- Services the UART receive side: captures `ReceivedData`/`ParityError` on `RxInterrupt`, drives a 4-phase `ClearInterrupt` handshake, and presents the byte on a valid/ready port.
- Sits between the UART instance and the system-side producers/consumers.

Parameters:
- NUM_REQ, 4, number of TX requesters (>=2).
- CLKS_PER_BIT, 868, clocks per serial bit; must match the UART baud divider.
- FRAME_BITS, 11, bits per frame (start + 8 data + parity + stop).
- GAP_BITS, 1, idle bit-times inserted after each frame.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: Already decided — one clock; reset is asynchronous and active-low.
- `ReqValid` in NUM_REQ: requester i holds a byte to send.
- `ReqData` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `ReqGrant` out NUM_REQ: one-hot, one-cycle pulse; byte of requester i has been taken.
- `TxBusy` out 1: high while a frame is being paced.
- `DataToTransmit` out 8: to UART.
- `Transmit` out 1: to UART, one-cycle start strobe.
- `RxInterrupt` in 1: from UART, byte received (level).
- `ReceivedData` in 8: from UART.
- `ParityError` in 1: from UART, valid with `RxInterrupt`.
- `ClearInterrupt` out 1: to UART, interrupt acknowledge.
- `RxValid` out 1: captured byte available.
- `RxData` out 8: captured byte.
- `RxParityErr` out 1: parity flag of the captured byte.
- `RxOverrun` out 1: at least one byte was dropped while `RxValid` was held.
- `RxReady` in 1: consumer accepts `RxData`.

Behaviour:
- Reset (async, `reset`=0): every output is 0; TX FSM=T_IDLE; RX FSM=R_IDLE; counter=0; RR pointer=NUM_REQ-1, so requester 0 wins first.
- FRAME_CYCLES = (FRAME_BITS+GAP_BITS)*CLKS_PER_BIT, which is 10416 at defaults. Counter width = $clog2(FRAME_CYCLES).

TX FSM {T_IDLE, T_WAIT}:
- T_IDLE, at an edge with ReqValid != 0:
  - winner = first set bit searching from pointer+1 with wrap-around;
  - register `DataToTransmit` <= ReqData[winner], `Transmit` <= 1, `ReqGrant` <= onehot(winner), pointer <= winner, counter <= 0;
  - go to T_WAIT.
- T_WAIT:
  - `Transmit` and `ReqGrant` fall after one cycle; `TxBusy` = 1.
  - counter increments every edge; at counter == FRAME_CYCLES-1 go to T_IDLE.
- Requesters may change `ReqData`/`ReqValid` from the cycle `ReqGrant` is high; the FSM does not resample in T_WAIT.
- Back-to-back spacing: consecutive `Transmit` rising edges are exactly FRAME_CYCLES+1 cycles apart (one T_IDLE cycle).
- `DataToTransmit` holds its value until the next load.
- `ReqValid` dropping before grant: the request is simply not served; there is no lockup.

RX FSM {R_IDLE, R_ACK}:
- R_IDLE, at an edge with `RxInterrupt`=1:
  - `ClearInterrupt` <= 1; go to R_ACK.
  - If `RxValid`=0, or `RxValid`&`RxReady` at this same edge: `RxData` <= `ReceivedData`, `RxParityErr` <= `ParityError`, `RxValid` <= 1.
  - Otherwise: keep the old byte, drop the new one, set `RxOverrun` <= 1.
- R_ACK: hold `ClearInterrupt`=1 until `RxInterrupt` is sampled 0, then `ClearInterrupt` <= 0 and go to R_IDLE. A new byte cannot be captured before the handshake completes.
- Consumer handshake:
  - `RxValid`&`RxReady` with no simultaneous capture clears `RxValid` next edge.
  - `RxOverrun` clears on any completed consumer handshake.
- TX and RX FSMs are independent; simultaneous events on both sides are both served in the same cycle.
- Reset mid-frame or mid-handshake: immediate return to reset values; a pending grant is lost and the requester must re-request.

Decomposition:
- Package uart_sched_pkg: tx_state_t, rx_state_t enums; FRAME_CYCLES function of the parameters; default constants 868/11/1.
- One sub-module, uart_rr_arbiter (NUM_REQ): combinational winner search from the pointer, plus the registered pointer update enabled by load.

Test Plan (CLKS_PER_BIT=4 ⇒ FRAME_CYCLES=48, except test 6):
1. ReqValid=0001, ReqData[0]=0xA5 → next edge: Transmit=1 for 1 cycle, DataToTransmit=0xA5, ReqGrant=0001, TxBusy=1 for 48 cycles.
2. ReqValid=1111 held, bytes 0x10/0x21/0x32/0x43 → grants in order 0,1,2,3,0; Transmit edges exactly 49 cycles apart.
3. RxInterrupt=1 with ReceivedData=0x5A, ParityError=1 → RxValid=1, RxData=0x5A, RxParityErr=1, ClearInterrupt=1. Drop RxInterrupt → ClearInterrupt=0 one edge later.
4. Two RX bytes 0x11 then 0x22 with RxReady=0 → RxData stays 0x11, RxOverrun=1. RxReady=1 → RxValid=0, RxOverrun=0. Repeat with RxReady=1 at the second capture edge → RxData=0x22, no overrun.
5. Assert reset=0 at cycle 20 of T_WAIT → all outputs 0 immediately. Release with ReqValid=0100 → grant to requester 2 with full 48-cycle pacing.
6. Defaults (868) with the UART instance, send 0x55 → serial frame observed at 868 clocks/bit, next Transmit at 10417 cycles.
